// File: rtl/wb_port_pkg.sv
// Shared constants, register map and helpers for the Wishbone user-port block.
package wb_port_pkg;

  localparam logic [31:0] BASE_ADDR = 32'h3000_0000;
  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;
  localparam logic [31:0] ID_VALUE  = 32'hAB60_0001;

  localparam int CHECK_W = 16;
  localparam int GPIN_W  = 16;
  localparam int IO_W    = 38;
  localparam int IRQ_W   = 3;

  localparam logic [7:0] OFS_CHECK  = 8'h00;
  localparam logic [7:0] OFS_COUNT  = 8'h04;
  localparam logic [7:0] OFS_CMP    = 8'h08;
  localparam logic [7:0] OFS_STATUS = 8'h0C;
  localparam logic [7:0] OFS_GPIN   = 8'h10;
  localparam logic [7:0] OFS_ID     = 8'h14;

  typedef enum logic [2:0] {
    REG_CHECK,
    REG_COUNT,
    REG_CMP,
    REG_STATUS,
    REG_GPIN,
    REG_ID,
    REG_NONE
  } reg_sel_e;

  typedef struct packed {
    logic check;
    logic count;
    logic cmp;
    logic status;
  } reg_wr_t;

  // Word-aligned decode; adr[1:0] never participates.
  function automatic reg_sel_e decode_ofs(input logic [7:0] ofs);
    reg_sel_e r;
    case (ofs & 8'hFC)
      OFS_CHECK:  r = REG_CHECK;
      OFS_COUNT:  r = REG_COUNT;
      OFS_CMP:    r = REG_CMP;
      OFS_STATUS: r = REG_STATUS;
      OFS_GPIN:   r = REG_GPIN;
      OFS_ID:     r = REG_ID;
      default:    r = REG_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = wdat[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_port_user_block_if.sv
// Wishbone classic slave bus bundle; signal names follow the slave's view.
interface wb_port_user_block_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_port_regif.sv
// Address decode, single-cycle ack and registered read mux for the register window.
module wb_port_regif
  import wb_port_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  wb_port_user_block_if.slave wb,
  input  logic [CHECK_W-1:0] check_i,
  input  logic [31:0]        count_i,
  input  logic [31:0]        cmp_i,
  input  logic               match_i,
  input  logic [GPIN_W-1:0]  gpin_i,
  output reg_wr_t            wr_o,
  output logic [31:0]        wr_data_o,
  output logic [3:0]         wr_sel_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        hit;
  reg_sel_e    reg_sel;
  logic [31:0] rd_data;
  logic [1:0]  unused_adr;

  assign unused_adr = wb.wbs_adr_i[1:0];

  // Gating on ack_q keeps a held strobe from re-triggering in the ack cycle.
  assign hit = wb.wbs_cyc_i && wb.wbs_stb_i && !ack_q &&
               (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign reg_sel = decode_ofs(wb.wbs_adr_i[7:0]);

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CHECK:  rd_data = {{(32-CHECK_W){1'b0}}, check_i};
      REG_COUNT:  rd_data = count_i;
      REG_CMP:    rd_data = cmp_i;
      REG_STATUS: rd_data = {31'b0, match_i};
      REG_GPIN:   rd_data = {{(32-GPIN_W){1'b0}}, gpin_i};
      REG_ID:     rd_data = ID_VALUE;
      default:    rd_data = '0;
    endcase
  end

  always_comb begin
    wr_o = '0;
    if (hit && wb.wbs_we_i) begin
      case (reg_sel)
        REG_CHECK:  wr_o.check  = 1'b1;
        REG_COUNT:  wr_o.count  = 1'b1;
        REG_CMP:    wr_o.cmp    = 1'b1;
        REG_STATUS: wr_o.status = 1'b1;
        default:    wr_o = '0;
      endcase
    end
  end

  assign wr_data_o = wb.wbs_dat_i;
  assign wr_sel_o  = wb.wbs_sel_i;

  assign ack_d = hit;
  assign dat_d = hit ? rd_data : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

endmodule

// File: rtl/wb_port_user_block.sv
// User-project Wishbone port: CHECK drives pads, free-running COUNT compared against CMP raises MATCH/irq[0].
module wb_port_user_block
  import wb_port_pkg::*;
(
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_port_user_block_if.slave wb,
  input  logic [IO_W-1:0]     io_in,
  output logic [IO_W-1:0]     io_out,
  output logic [IO_W-1:0]     io_oeb,
  output logic [IRQ_W-1:0]    irq
);

  logic [CHECK_W-1:0] check_q, check_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        cmp_q, cmp_d;
  logic               match_q, match_d;

  reg_wr_t            wr;
  logic [31:0]        wr_data;
  logic [3:0]         wr_sel;
  logic [31:0]        check_merged;
  logic [IO_W-GPIN_W-1:0] unused_io;

  assign unused_io = io_in[IO_W-1:GPIN_W];

  wb_port_regif u_regif (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .wb        (wb),
    .check_i   (check_q),
    .count_i   (count_q),
    .cmp_i     (cmp_q),
    .match_i   (match_q),
    .gpin_i    (io_in[GPIN_W-1:0]),
    .wr_o      (wr),
    .wr_data_o (wr_data),
    .wr_sel_o  (wr_sel)
  );

  assign check_merged = merge_lanes({{(32-CHECK_W){1'b0}}, check_q}, wr_data, wr_sel);

  always_comb begin
    check_d = wr.check ? check_merged[CHECK_W-1:0] : check_q;
    // A COUNT write replaces the increment; unwritten lanes hold the pre-edge value.
    count_d = wr.count ? merge_lanes(count_q, wr_data, wr_sel) : count_q + 32'd1;
    cmp_d   = wr.cmp ? merge_lanes(cmp_q, wr_data, wr_sel) : cmp_q;
    match_d = match_q;
    if (wr.status && wr_sel[0] && wr_data[0]) match_d = 1'b0;
    if (count_q == cmp_q) match_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      check_q <= '0;
      count_q <= '0;
      cmp_q   <= CMP_RESET;
      match_q <= 1'b0;
    end else begin
      check_q <= check_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  assign io_out = {{(IO_W-32){1'b0}}, check_q, 16'h0000};
  assign io_oeb = {{(IO_W-32){1'b1}}, 16'h0000, 16'hFFFF};
  assign irq    = {{(IRQ_W-1){1'b0}}, match_q};

endmodule

// File: tb/tb_wb_port_user_block.sv
// Directed + randomized bench for wb_port_user_block against a cycle-indexed register model.
module tb_wb_port_user_block;
  import wb_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [37:0] io_in;
  logic [37:0] io_out;
  logic [37:0] io_oeb;
  logic [2:0]  irq;

  wb_port_user_block_if bus();

  wb_port_user_block dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: COUNT is "base value plus edges elapsed since base was set".
  logic [15:0] m_check;
  logic [31:0] m_cmp;
  logic [31:0] m_cnt_base;
  int unsigned m_cnt_edge;
  logic        m_match;

  localparam logic [37:0] OEB_EXP = {6'h3F, 16'h0000, 16'hFFFF};

  function automatic logic [31:0] m_count_after(input int unsigned e);
    return m_cnt_base + 32'(e - m_cnt_edge);
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] ofs, input int unsigned e);
    logic [7:0] w;
    w = {ofs[7:2], 2'b00};
    case (w)
      8'h00:   return {16'h0, m_check};
      8'h04:   return m_count_after(e - 1);
      8'h08:   return m_cmp;
      8'h0C:   return {31'h0, m_match};
      8'h10:   return {16'h0, io_in[15:0]};
      8'h14:   return 32'hAB60_0001;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output logic acked,
                      output int unsigned hit_e);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    acked = 1'b0;
    rd    = '0;
    hit_e = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o === 1'b1) begin
        acked = 1'b1;
        hit_e = edge_n;
        rd    = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    if (acked) begin
      @(posedge clk); #1;
      check("ack_one_cycle", bus.wbs_ack_o, 1'b0);
      check("dat_idle_zero", bus.wbs_dat_o, 32'h0);
    end
  endtask

  task automatic do_write(input logic [7:0] ofs, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd, tmp;
    logic acked;
    int unsigned e;
    xfer(1'b1, BASE_ADDR | {24'h0, ofs}, dat, sel, rd, acked, e);
    check("write_ack", acked, 1'b1);
    case ({ofs[7:2], 2'b00})
      8'h00: begin tmp = lanes({16'h0, m_check}, dat, sel); m_check = tmp[15:0]; end
      8'h04: begin m_cnt_base = lanes(m_count_after(e - 1), dat, sel); m_cnt_edge = e; end
      8'h08: m_cmp = lanes(m_cmp, dat, sel);
      8'h0C: if (sel[0] && dat[0]) m_match = 1'b0;
      default: ;
    endcase
    check("io_out_check", io_out, {6'h0, m_check, 16'h0});
    check("io_oeb", io_oeb, OEB_EXP);
  endtask

  task automatic do_read(input string tag, input logic [31:0] adr);
    logic [31:0] rd;
    logic acked;
    int unsigned e;
    xfer(1'b0, adr, 32'h0, 4'hF, rd, acked, e);
    check({tag, "_ack"}, acked, 1'b1);
    check(tag, rd, exp_read(adr[7:0], e));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    m_check    = '0;
    m_cmp      = CMP_RESET;
    m_match    = 1'b0;
    m_cnt_base = '0;
    m_cnt_edge = edge_n;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, bus.wbs_ack_o, 1'b0);
    check({tag, "_dat"}, bus.wbs_dat_o, 32'h0);
    check({tag, "_io_out"}, io_out, 38'h0);
    check({tag, "_io_oeb"}, io_oeb, OEB_EXP);
    check({tag, "_irq"}, irq, 3'b000);
  endtask

  initial begin
    logic [31:0] rd;
    logic acked;
    int unsigned e, match_e;
    int op;
    logic [7:0] ofs;

    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    io_in = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();
    do_read("rd_cmp_reset", BASE_ADDR | 32'h08);
    do_read("rd_count_start", BASE_ADDR | 32'h04);

    do_write(8'h00, 32'h0000_AB60, 4'hF);
    check("check_ab60", io_out[31:16], 16'hAB60);
    do_write(8'h00, 32'h0000_AB61, 4'hF);
    check("check_ab61", io_out[31:16], 16'hAB61);

    do_write(8'h00, 32'h0000_AB60, 4'hF);
    do_write(8'h00, 32'h0000_1200, 4'h2);
    check("check_lane1", io_out[31:16], 16'h1260);
    do_read("rd_check", BASE_ADDR | 32'h00);

    do_read("rd_id", BASE_ADDR | 32'h14);
    do_read("rd_id_unaligned", BASE_ADDR | 32'h17);
    do_read("rd_unmapped", BASE_ADDR | 32'h40);
    do_write(8'h44, 32'hFFFF_FFFF, 4'hF);
    do_read("rd_check_after_unmapped_wr", BASE_ADDR | 32'h00);
    xfer(1'b0, BASE_ADDR + 32'h100, 32'h0, 4'hF, rd, acked, e);
    check("no_ack_outside_window", acked, 1'b0);

    io_in = {22'h2A_AAAA, 16'h5A5A};
    do_read("rd_gpin_5a5a", BASE_ADDR | 32'h10);

    for (int k = 0; k < 40; k++) begin
      op  = int'($urandom_range(0, 8));
      ofs = 8'($urandom_range(0, 3));
      case (op)
        0: do_write(8'h00 | ofs, $urandom, 4'($urandom));
        1: do_write(8'h04 | ofs, $urandom, 4'($urandom));
        2: do_write(8'h08 | ofs, $urandom, 4'($urandom));
        3: do_read("rnd_check", BASE_ADDR | {24'h0, 8'h00 | ofs});
        4: do_read("rnd_count", BASE_ADDR | {24'h0, 8'h04 | ofs});
        5: do_read("rnd_cmp", BASE_ADDR | {24'h0, 8'h08 | ofs});
        6: begin
             io_in = {6'($urandom), 32'($urandom)};
             do_read("rnd_gpin", BASE_ADDR | {24'h0, 8'h10 | ofs});
           end
        7: do_read("rnd_id", BASE_ADDR | {24'h0, 8'h14 | ofs});
        default: do_read("rnd_unmapped", BASE_ADDR | {24'h0, 8'($urandom_range(6, 63)) << 2});
      endcase
    end

    do_write(8'h08, 32'h0000_0001, 4'hF);
    do_write(8'h0C, 32'h0000_0001, 4'hF);
    check("irq_cleared_pre", irq, 3'b000);
    do_write(8'h04, 32'hFFFF_FFFE, 4'hF);
    // MATCH is visible one edge after COUNT reaches CMP.
    match_e = m_cnt_edge + 32'(m_cmp - m_cnt_base) + 1;
    for (int k = 0; k < 8; k++) begin
      check("irq0_vs_match_time", irq[0], (edge_n >= match_e));
      if (edge_n > match_e) break;
      @(posedge clk); #1;
    end
    check("irq_upper_zero", irq[2:1], 2'b00);
    m_match = 1'b1;
    do_read("rd_count_wrapped", BASE_ADDR | 32'h04);
    do_read("rd_status_set", BASE_ADDR | 32'h0C);
    do_write(8'h0C, 32'h0000_0001, 4'h0);
    check("w1c_no_lane_keeps", irq[0], 1'b1);
    do_write(8'h0C, 32'h0000_0001, 4'h1);
    check("w1c_clears_irq", irq[0], 1'b0);
    do_read("rd_status_clear", BASE_ADDR | 32'h0C);

    do_write(8'h00, 32'h0000_BEEF, 4'hF);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = BASE_ADDR;
    bus.wbs_dat_i = 32'h0000_1234;
    bus.wbs_sel_i = 4'hF;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_mid_xfer");
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(posedge clk); #1;
    check("rst_hold_ack", bus.wbs_ack_o, 1'b0);
    release_reset();
    do_read("rd_check_after_rst", BASE_ADDR | 32'h00);
    do_read("rd_cmp_after_rst", BASE_ADDR | 32'h08);
    do_read("rd_count_after_rst", BASE_ADDR | 32'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
